// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 8-bit single-cycle CPU: program counter, 256x8 instruction
// memory with a load port, run/halt sequencer and a saturating retired-instruction counter.
module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              branch,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [CNT_W-1:0]  retired_reg;
  logic              instr_valid_reg;
  logic              halted_reg;

  logic [7:0]        mem [DEPTH];

  logic [5:0]        off;
  logic              jump_self;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_target;
  logic [CNT_W-1:0]  retired_inc;

  // Instruction read is combinational so the decoder sees mem[pc] in the same cycle.
  assign instr       = mem[pc_reg];
  assign off         = instr[5:0];
  assign jump_self   = &off;
  assign pc_inc      = pc_reg + ADDR_W'(1);
  assign pc_target   = pc_inc + {{(ADDR_W-6){off[5]}}, off};
  assign retired_inc = (&retired_reg) ? retired_reg : retired_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (state_reg == IDLE && load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      retired_reg     <= '0;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (start) begin
            state_reg       <= RUN;
            pc_reg          <= '0;
            retired_reg     <= '0;
            instr_valid_reg <= 1'b1;
            halted_reg      <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            retired_reg <= retired_inc;
            if (branch && jump_self) begin
              // A jump to itself is the program's way of saying it is done.
              state_reg       <= HALT;
              instr_valid_reg <= 1'b0;
              halted_reg      <= 1'b1;
            end else if (branch) begin
              pc_reg <= pc_target;
            end else begin
              pc_reg <= pc_inc;
            end
          end
        end
        default: begin
          state_reg       <= IDLE;
          instr_valid_reg <= 1'b0;
          halted_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_reg;
  assign retired     = retired_reg;
  assign instr_valid = instr_valid_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a cycle-level
// behavioural model (state number, pc, retired count and a copy of program memory).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_we = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [7:0]  pc;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = run, 2 = halt
  int          m_state = 0;
  logic [7:0]  m_pc = '0;
  logic [15:0] m_ret = '0;
  logic [7:0]  m_mem [256];

  instr_fetch_unit #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .branch(branch),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // Advance one clock and apply the same rules to the model using the inputs seen at the edge.
  task automatic tick();
    int off;
    logic [7:0] ins;
    @(posedge clk);
    ins = m_mem[m_pc];
    case (m_state)
      0: begin
        if (load_we) m_mem[load_addr] = load_data;
        if (start) begin m_state = 1; m_pc = 0; m_ret = 0; end
      end
      1: if (!stall) begin
        if (m_ret != 16'hFFFF) m_ret = m_ret + 1;
        if (branch) begin
          off = int'(ins[5:0]);
          if (off == 63) m_state = 2;
          else begin
            if (off >= 32) off = off - 64;
            m_pc = 8'((int'(m_pc) + 1 + off + 256) % 256);
          end
        end else begin
          m_pc = 8'((int'(m_pc) + 1) % 256);
        end
      end
      default: if (start) begin m_state = 1; m_pc = 0; m_ret = 0; end
    endcase
    #1;
  endtask

  // Decoder stand-in: opcode 2'b11 is the J-type instruction.
  task automatic drive_branch();
    branch = (m_state == 1) && (m_mem[m_pc][7:6] == 2'b11);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load_we = 0; start = 0; stall = 0; branch = 0;
    m_state = 0; m_pc = 0; m_ret = 0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pc, instr_valid, halted, retired} !== {8'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_hold: got %h exp %h", {pc, instr_valid, halted, retired}, 26'd0);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({pc, instr_valid, halted, retired} !== {8'd0, 1'b0, 1'b0, 16'd0}) begin
        errors++; $display("FAIL idle_hold cyc %0d: got %h exp %h", i, {pc, instr_valid, halted, retired}, 26'd0);
      end
    end
  endtask

  task automatic test_load_seq();
    logic [7:0] prog [4];
    prog[0] = 8'h01; prog[1] = 8'h42; prog[2] = 8'h83; prog[3] = 8'hFF;
    for (int a = 0; a < 256; a++)
      load_byte(8'(a), (a < 4) ? prog[a] : 8'($urandom_range(0, 191)));
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({pc, instr, instr_valid, halted, retired} !== {8'(i), prog[i], 1'b1, 1'b0, 16'(i)}) begin
        errors++; $display("FAIL seq_run cyc %0d: got %h exp %h", i,
          {pc, instr, instr_valid, halted, retired}, {8'(i), prog[i], 1'b1, 1'b0, 16'(i)});
      end
      drive_branch(); tick();
    end
    branch = 1'b0;
    checks++;
    if ({pc, instr_valid, halted, retired} !== {8'd3, 1'b0, 1'b1, 16'd4}) begin
      errors++; $display("FAIL seq_halt: got %h exp %h", {pc, instr_valid, halted, retired}, {8'd3, 1'b0, 1'b1, 16'd4});
    end
  endtask

  task automatic test_jumps();
    int exp_pc [10] = '{0, 1, 2, 6, 0, 1, 2, 6, 0, 1};
    do_reset();
    load_byte(8'd0, 8'h05); load_byte(8'd1, 8'h10);
    load_byte(8'd2, 8'hC3); load_byte(8'd6, 8'hF9);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({pc, instr, instr_valid, halted, retired} !== {8'(exp_pc[i]), m_mem[m_pc], 1'b1, 1'b0, 16'(i)}) begin
        errors++; $display("FAIL jump cyc %0d: got %h exp %h", i,
          {pc, instr, instr_valid, halted, retired}, {8'(exp_pc[i]), m_mem[m_pc], 1'b1, 1'b0, 16'(i)});
      end
      drive_branch(); tick();
    end
    branch = 1'b0;
  endtask

  task automatic test_wrap_stall();
    int stalls = 0;
    logic [7:0] prev;
    logic was_stall;
    do_reset();
    for (int a = 0; a < 256; a++) load_byte(8'(a), 8'($urandom_range(0, 191)));
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 259; i++) begin
      stall = (m_pc == 8'd10) && (stalls < 3);
      if (stall) stalls++;
      prev = m_pc; was_stall = stall;
      drive_branch(); tick();
      checks++;
      if ({pc, instr, instr_valid, halted, retired} !== {m_pc, m_mem[m_pc], m_state == 1, m_state == 2, m_ret}) begin
        errors++; $display("FAIL wrap_model cyc %0d: got %h exp %h", i,
          {pc, instr, instr_valid, halted, retired}, {m_pc, m_mem[m_pc], m_state == 1, m_state == 2, m_ret});
      end
      if (was_stall) begin
        checks++;
        if ({pc, retired} !== {8'd10, 16'd10}) begin
          errors++; $display("FAIL stall_hold cyc %0d: got %h exp %h", i, {pc, retired}, {8'd10, 16'd10});
        end
      end
      if (prev == 8'd255 && !was_stall) begin
        checks++;
        if ({pc, retired} !== {8'd0, 16'd256}) begin
          errors++; $display("FAIL pc_wrap: got %h exp %h", {pc, retired}, {8'd0, 16'd256});
        end
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_ignored();
    int n;
    do_reset();
    for (int a = 0; a < 16; a++) load_byte(8'(a), 8'($urandom_range(0, 191)));
    load_byte(8'd5, 8'h2A); load_byte(8'd9, 8'hFF);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (m_state == 1 && n < 30) begin
      load_we = (m_pc == 8'd2); load_addr = 8'd5; load_data = 8'h99;
      start = (m_pc == 8'd4);
      drive_branch(); tick();
      load_we = 1'b0; start = 1'b0; n++;
      checks++;
      if ({pc, instr, instr_valid, halted, retired} !== {m_pc, m_mem[m_pc], m_state == 1, m_state == 2, m_ret}) begin
        errors++; $display("FAIL ignore_model cyc %0d: got %h exp %h", n,
          {pc, instr, instr_valid, halted, retired}, {m_pc, m_mem[m_pc], m_state == 1, m_state == 2, m_ret});
      end
    end
    branch = 1'b0;
    checks++;
    if ({halted, pc, retired} !== {1'b1, 8'd9, 16'd10}) begin
      errors++; $display("FAIL ignore_halt: got %h exp %h", {halted, pc, retired}, {1'b1, 8'd9, 16'd10});
    end
    load_byte(8'd5, 8'h77);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({pc, retired, instr_valid, halted} !== {8'd0, 16'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL restart_halt: got %h exp %h", {pc, retired, instr_valid, halted}, {8'd0, 16'd0, 1'b1, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin drive_branch(); tick(); end
    checks++;
    if ({pc, instr} !== {8'd5, 8'h2A}) begin
      errors++; $display("FAIL mem5_kept: got %h exp %h", {pc, instr}, {8'd5, 8'h2A});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int a = 0; a < 20; a++) load_byte(8'(a), 8'($urandom_range(0, 191)));
    load_byte(8'd20, 8'hFF);
    for (int run = 0; run < 2; run++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 7; i++) begin drive_branch(); tick(); end
      checks++;
      if ({pc, instr, retired} !== {8'd7, m_mem[7], 16'd7}) begin
        errors++; $display("FAIL rerun_%0d: got %h exp %h", run, {pc, instr, retired}, {8'd7, m_mem[7], 16'd7});
      end
      #2 reset_n = 1'b0;
      m_state = 0; m_pc = 0; m_ret = 0;
      #1;
      checks++;
      if ({pc, instr, instr_valid, halted, retired} !== {8'd0, m_mem[0], 1'b0, 1'b0, 16'd0}) begin
        errors++; $display("FAIL async_reset_%0d: got %h exp %h", run,
          {pc, instr, instr_valid, halted, retired}, {8'd0, m_mem[0], 1'b0, 1'b0, 16'd0});
      end
      @(negedge clk); reset_n = 1'b1; branch = 1'b0;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int a = 0; a < 256; a++) load_byte(8'(a), 8'($urandom));
    for (int i = 0; i < 800; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      start = (m_state == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      load_we = ($urandom_range(0, 3) == 0); load_addr = 8'($urandom); load_data = 8'($urandom);
      drive_branch(); tick();
      checks++;
      if ({pc, instr, instr_valid, halted, retired} !== {m_pc, m_mem[m_pc], m_state == 1, m_state == 2, m_ret}) begin
        errors++; $display("FAIL random cyc %0d: got %h exp %h", i,
          {pc, instr, instr_valid, halted, retired}, {m_pc, m_mem[m_pc], m_state == 1, m_state == 2, m_ret});
      end
    end
    stall = 0; start = 0; load_we = 0; branch = 0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
    test_reset();
    test_load_seq();
    test_jumps();
    test_wrap_stall();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
